// File: rtl/jtag_tap_driver.sv
// JTAG initiator: one IR scan plus optional DR scan (<=32 bits) per command; latency (IR_LEN+6+(len?len+5:0))*2*CLK_DIV+1 clocks.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are dropped, never queued.
module jtag_tap_driver #(
  parameter int CLK_DIV = 2,
  parameter int IR_LEN  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IR_LEN-1:0] cmd_ir,
  input  logic [5:0]        cmd_dr_len,
  input  logic [31:0]       cmd_dr_data,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              busy,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);

  typedef enum logic [2:0] {RESET_SEQ, IDLE, IR_SCAN, DR_SCAN, DONE} state_t;

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] RISE = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] FALL = PW'(2 * CLK_DIV - 1);

  state_t            state;
  logic [PW-1:0]     phase;
  logic [5:0]        step;
  logic [IR_LEN-1:0] ir_q;
  logic [5:0]        len_q;
  logic [31:0]       data_q;
  logic [31:0]       capture;
  int                step_i;
  int                len_i;

  assign step_i = int'(step);
  assign len_i  = int'(len_q);

  function automatic int cycles(state_t st);
    case (st)
      IR_SCAN: return IR_LEN + 6;
      DR_SCAN: return len_i + 5;
      default: return 6;
    endcase
  endfunction

  // TMS for TCK cycle i of a sequence; the TAP always ends back in Run-Test/Idle.
  function automatic logic tms_at(state_t st, int i);
    case (st)
      RESET_SEQ: return i < 5;
      IR_SCAN: begin
        if (i < 4) return i < 2;
        else if (i < IR_LEN + 4) return i == IR_LEN + 3;
        else return i == IR_LEN + 4;
      end
      DR_SCAN: begin
        if (i < 3) return i == 0;
        else if (i < len_i + 3) return i == len_i + 2;
        else return i == len_i + 3;
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic tdi_at(state_t st, int i);
    logic [IR_LEN-1:0] irs;
    logic [31:0]       drs;
    if (st == IR_SCAN && i >= 4 && i < IR_LEN + 4) begin
      irs = ir_q >> (i - 4);
      return irs[0];
    end else if (st == DR_SCAN && i >= 3 && i < len_i + 3) begin
      drs = data_q >> (i - 3);
      return drs[0];
    end
    return 1'b0;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RESET_SEQ;
      phase     <= '0;
      step      <= '0;
      TCK       <= 1'b0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      ir_q      <= '0;
      len_q     <= '0;
      data_q    <= '0;
      capture   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            ir_q      <= cmd_ir;
            len_q     <= (cmd_dr_len > 6'd32) ? 6'd32 : cmd_dr_len;
            data_q    <= cmd_dr_data;
            capture   <= '0;
            state     <= IR_SCAN;
            step      <= '0;
            phase     <= '0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else if (!cmd_ready) begin
            // one dead IDLE clock after a response keeps rsp_valid and accept apart
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE: begin
          rsp_valid <= 1'b1;
          rsp_data  <= capture;
          state     <= IDLE;
        end
        RESET_SEQ, IR_SCAN, DR_SCAN: begin
          if (phase == RISE) begin
            TCK   <= 1'b1;
            phase <= phase + 1'b1;
            if (state == DR_SCAN && step_i >= 3 && step_i < len_i + 3)
              capture <= capture | ({31'd0, TDO} << (step_i - 3));
          end else if (phase == FALL) begin
            TCK   <= 1'b0;
            phase <= '0;
            if (step_i != cycles(state) - 1) begin
              step <= step + 6'd1;
              TMS  <= tms_at(state, step_i + 1);
              TDI  <= tdi_at(state, step_i + 1);
            end else begin
              step <= '0;
              TDI  <= 1'b0;
              case (state)
                IR_SCAN: begin
                  if (len_q != 6'd0) begin
                    state <= DR_SCAN;
                    TMS   <= 1'b1;
                  end else begin
                    state <= DONE;
                    TMS   <= 1'b0;
                  end
                end
                DR_SCAN: begin
                  state <= DONE;
                  TMS   <= 1'b0;
                end
                default: begin
                  state     <= IDLE;
                  TMS       <= 1'b0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                end
              endcase
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: state <= RESET_SEQ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Directed bench for jtag_tap_driver (CLK_DIV=2, IR_LEN=8) with an independent TAP state-machine model on TCK.
module tb_jtag_tap_driver;

  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6, EX2DR = 7,
                 UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_ir = '0;
  logic [5:0]  cmd_dr_len = '0;
  logic [31:0] cmd_dr_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  logic        TCK, TMS, TDI, TDO;

  int checks = 0;
  int failures = 0;
  int tdo_mode = 0;  // 0: tied low, 1: loopback TDI, 2: tied high

  int         tap_state = TLR;
  logic [7:0] ir_sh = '0;
  logic [7:0] ir_reg = '0;
  int         tck_rises = 0, tms1_rises = 0, dr_shifts = 0, dr_caps = 0, rsp_count = 0;

  jtag_tap_driver #(.CLK_DIV(2), .IR_LEN(8)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr_len(cmd_dr_len), .cmd_dr_data(cmd_dr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 clock = ~clock;

  assign TDO = (tdo_mode == 1) ? TDI : (tdo_mode == 2);

  function automatic int tap_next(int s, logic t);
    case (s)
      TLR:     return t ? TLR   : RTI;
      RTI:     return t ? SELDR : RTI;
      SELDR:   return t ? SELIR : CAPDR;
      CAPDR:   return t ? EX1DR : SHDR;
      SHDR:    return t ? EX1DR : SHDR;
      EX1DR:   return t ? UPDR  : PADR;
      PADR:    return t ? EX2DR : PADR;
      EX2DR:   return t ? UPDR  : SHDR;
      UPDR:    return t ? SELDR : RTI;
      SELIR:   return t ? TLR   : CAPIR;
      CAPIR:   return t ? EX1IR : SHIR;
      SHIR:    return t ? EX1IR : SHIR;
      EX1IR:   return t ? UPIR  : PAIR;
      PAIR:    return t ? EX2IR : PAIR;
      EX2IR:   return t ? UPIR  : SHIR;
      default: return t ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge TCK) begin
    tck_rises++;
    if (TMS) tms1_rises++;
    if (tap_state == SHIR) ir_sh = {TDI, ir_sh[7:1]};
    if (tap_state == SHDR) dr_shifts++;
    tap_state = tap_next(tap_state, TMS);
    if (tap_state == UPIR) ir_reg = ir_sh;
    if (tap_state == CAPDR) dr_caps++;
  end

  always @(posedge clock) if (rsp_valid) rsp_count++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] ir, input logic [5:0] len, input logic [31:0] data);
    cmd_ir = ir; cmd_dr_len = len; cmd_dr_data = data; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 2000) begin tick(); n++; end
    if (rsp_valid !== 1'b1) n = -1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin tick(); n++; end
    if (cmd_ready !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    int n, t0, m0, bad;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({TCK, TMS, TDI, cmd_ready, busy, rsp_valid} !== 6'b010010) begin
      failures++; $display("FAIL reset_outputs got=%b exp=010010", {TCK, TMS, TDI, cmd_ready, busy, rsp_valid});
    end
    checks++;
    if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    t0 = tck_rises; m0 = tms1_rises;
    reset = 1'b0;
    wait_ready(n);
    checks++;
    if (n !== 24) begin failures++; $display("FAIL reset_ready_latency got=%0d exp=24", n); end
    checks++;
    if (tck_rises - t0 !== 6) begin failures++; $display("FAIL reset_tck_edges got=%0d exp=6", tck_rises - t0); end
    checks++;
    if (tms1_rises - m0 !== 5) begin failures++; $display("FAIL reset_tms1_edges got=%0d exp=5", tms1_rises - m0); end
    checks++;
    if (tap_state !== RTI || busy !== 1'b0) begin
      failures++; $display("FAIL reset_end_state tap=%0d busy=%b exp tap=%0d busy=0", tap_state, busy, RTI);
    end
    bad = 0;
    repeat (10) begin tick(); if (TCK !== 1'b0 || TMS !== 1'b0 || cmd_ready !== 1'b1) bad++; end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL idle_quiet bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_loopback();
    int n, t0, s0;
    tdo_mode = 1; t0 = tck_rises; s0 = dr_shifts;
    send(8'h32, 6'd8, 32'hA5);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL accept_ready ready=%b busy=%b exp 0/1", cmd_ready, busy);
    end
    wait_rsp(n);
    checks++;
    if (n !== 109) begin failures++; $display("FAIL loop_latency got=%0d exp=109", n); end
    checks++;
    if (rsp_data !== 32'h000000A5) begin failures++; $display("FAIL loop_data got=%h exp=000000a5", rsp_data); end
    checks++;
    if (tck_rises - t0 !== 27) begin failures++; $display("FAIL loop_tck_edges got=%0d exp=27", tck_rises - t0); end
    checks++;
    if (dr_shifts - s0 !== 8) begin failures++; $display("FAIL loop_dr_shifts got=%0d exp=8", dr_shifts - s0); end
    checks++;
    if (tap_state !== RTI || ir_reg !== 8'h32) begin
      failures++; $display("FAIL loop_tap tap=%0d ir=%h exp tap=%0d ir=32", tap_state, ir_reg, RTI);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== 32'hA5) begin
      failures++; $display("FAIL loop_after vld=%b rdy=%b data=%h exp 0/1/a5", rsp_valid, cmd_ready, rsp_data);
    end
  endtask

  task automatic test_ir_only();
    int n, t0, c0, r0;
    tdo_mode = 1; t0 = tck_rises; c0 = dr_caps; r0 = rsp_count;
    send(8'h5C, 6'd0, 32'hFFFFFFFF);
    wait_rsp(n);
    checks++;
    if (n !== 57) begin failures++; $display("FAIL iro_latency got=%0d exp=57", n); end
    checks++;
    if (rsp_data !== 32'h0) begin failures++; $display("FAIL iro_data got=%h exp=0", rsp_data); end
    checks++;
    if (tck_rises - t0 !== 14) begin failures++; $display("FAIL iro_tck_edges got=%0d exp=14", tck_rises - t0); end
    checks++;
    if (dr_caps - c0 !== 0 || ir_reg !== 8'h5C) begin
      failures++; $display("FAIL iro_tap dr_caps=%0d ir=%h exp 0/5c", dr_caps - c0, ir_reg);
    end
    repeat (5) tick();
    checks++;
    if (rsp_count - r0 !== 1) begin failures++; $display("FAIL iro_rsp_pulses got=%0d exp=1", rsp_count - r0); end
  endtask

  task automatic test_clamp();
    int n, t0, s0;
    tdo_mode = 1; t0 = tck_rises; s0 = dr_shifts;
    send(8'hA3, 6'd40, 32'hDEADBEEF);
    wait_rsp(n);
    checks++;
    if (n !== 205) begin failures++; $display("FAIL clamp_latency got=%0d exp=205", n); end
    checks++;
    if (rsp_data !== 32'hDEADBEEF) begin failures++; $display("FAIL clamp_data got=%h exp=deadbeef", rsp_data); end
    checks++;
    if (tck_rises - t0 !== 51 || dr_shifts - s0 !== 32) begin
      failures++; $display("FAIL clamp_edges tck=%0d shifts=%0d exp 51/32", tck_rises - t0, dr_shifts - s0);
    end
    tick();
  endtask

  task automatic test_tdo_high();
    int n;
    tdo_mode = 2;
    send(8'h01, 6'd5, 32'h0);
    wait_rsp(n);
    checks++;
    if (n !== 97) begin failures++; $display("FAIL tdo1_latency got=%0d exp=97", n); end
    checks++;
    if (rsp_data !== 32'h0000001F) begin failures++; $display("FAIL tdo1_data got=%h exp=0000001f", rsp_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    tdo_mode = 1;
    send(8'h0F, 6'd3, 32'h5);
    wait_rsp(n);
    checks++;
    if (n !== 89 || rsp_data !== 32'h5) begin
      failures++; $display("FAIL b2b_first n=%0d data=%h exp 89/5", n, rsp_data);
    end
    cmd_ir = 8'hF0; cmd_dr_len = 6'd2; cmd_dr_data = 32'hFFFFFFFE; cmd_valid = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_not_taken ready=%b busy=%b exp 1/0", cmd_ready, busy);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_taken ready=%b exp=0", cmd_ready); end
    wait_rsp(n);
    checks++;
    if (n !== 85 || rsp_data !== 32'h2 || ir_reg !== 8'hF0) begin
      failures++; $display("FAIL b2b_second n=%0d data=%h ir=%h exp 85/2/f0", n, rsp_data, ir_reg);
    end
    tick();
  endtask

  task automatic test_reset_mid_scan();
    int n, s0, r0, t0, rdy_seen;
    tdo_mode = 1; s0 = dr_shifts; r0 = rsp_count;
    send(8'h11, 6'd8, 32'hFF);
    cmd_ir = 8'hAA; cmd_dr_len = 6'd4; cmd_dr_data = 32'h3; cmd_valid = 1'b1;
    rdy_seen = 0;
    repeat (10) begin tick(); if (cmd_ready !== 1'b0) rdy_seen++; end
    cmd_valid = 1'b0;
    checks++;
    if (rdy_seen !== 0) begin failures++; $display("FAIL busy_drop ready_cycles=%0d exp=0", rdy_seen); end
    repeat (71) tick();
    checks++;
    if (dr_shifts - s0 !== 3 || tap_state !== SHDR) begin
      failures++; $display("FAIL mid_position shifts=%0d tap=%0d exp 3/%0d", dr_shifts - s0, tap_state, SHDR);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({TCK, TMS, cmd_ready, busy, rsp_valid} !== 5'b01010) begin
      failures++; $display("FAIL mid_reset_outputs got=%b exp=01010", {TCK, TMS, cmd_ready, busy, rsp_valid});
    end
    reset = 1'b0; t0 = tck_rises;
    wait_ready(n);
    checks++;
    if (n !== 24 || tck_rises - t0 !== 6 || tap_state !== RTI) begin
      failures++; $display("FAIL mid_replay n=%0d edges=%0d tap=%0d exp 24/6/%0d", n, tck_rises - t0, tap_state, RTI);
    end
    repeat (5) tick();
    checks++;
    if (rsp_count - r0 !== 0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL mid_no_rsp pulses=%0d ready=%b exp 0/1", rsp_count - r0, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_ir_only();
    test_clamp();
    test_tdo_high();
    test_back_to_back();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtag_tap_driver.md
# jtag_tap_driver

Host-side JTAG initiator for on-chip self-test and bring-up. It generates TCK/TMS/TDI toward a TAP, such as the FPGA's JTAG port feeding the user chains (JCE1/JCE2, JSHIFT, JUPDATE, JTD1/JTD2), and samples TDO. Each command performs a full IR scan followed by an optional DR scan of up to 32 bits, and returns the captured DR bits. It is the initiator counterpart of the chain1/chain2 user-register logic. All timing is derived from one system clock.

## Interface
- CLK_DIV, 2, system clocks per TCK half-period (≥1)
- IR_LEN, 8, instruction register length in bits (1..16)
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; the command is accepted when cmd_valid & cmd_ready
- cmd_ir  in  IR_LEN  instruction shifted into IR, LSB first
- cmd_dr_len  in  6  DR bits to shift: 0 = IR-only scan; 33..63 are clamped to 32
- cmd_dr_data  in  32  DR data, LSB first; bits ≥ len are ignored
- rsp_valid  out  1  one-cycle pulse when a command completes
- rsp_data  out  32  captured TDO bits; bit k = k-th DR bit shifted out; bits ≥ len are 0; held until the next rsp_valid
- busy  out  1  inverse of cmd_ready
- TCK  out  1  JTAG clock
- TMS  out  1  JTAG mode select
- TDI  out  1  JTAG data to TAP
- TDO  in  1  JTAG data from TAP

## Operation
- Reset values: TCK=0, TMS=1, TDI=0, cmd_ready=0, busy=1, rsp_valid=0, rsp_data=0, state=RESET_SEQ.
- TCK cycle: a low phase of CLK_DIV clocks, then a high phase of CLK_DIV clocks.
- TMS and TDI change only at the start of a low phase (TCK falling, or entry from idle).
- TDO is sampled on the clock at which TCK is driven high.
- States:
  - RESET_SEQ: 5 TCK cycles with TMS=1 (Test-Logic-Reset), then 1 with TMS=0 (Run-Test/Idle), then → IDLE.
  - IDLE: TCK=0, TMS=0, TDI=0, cmd_ready=1. On accept: latch cmd_ir, clamped len and cmd_dr_data; clear the capture register; → IR_SCAN.
  - IR_SCAN: TMS sequence 1,1,0,0, then IR_LEN shift cycles (TMS=0 except the last, which is 1), then 1,0. TDI carries cmd_ir[i] during shift cycle i; TDI=0 otherwise. Next state is DR_SCAN if len>0, else DONE.
  - DR_SCAN: TMS sequence 1,0,0, then len shift cycles (last has TMS=1), then 1,0. TDI carries data[i] during shift i. TDO sampled at shift i is stored to capture[i].
  - DONE: one clock with rsp_valid=1 and rsp_data=capture; → IDLE.
- TCK cycle counts: IR scan = IR_LEN+6; DR scan = len+5; the TAP ends in Run-Test/Idle after every scan.
- cmd_valid while busy is ignored; no queueing.
- reset at any time, including mid-scan: outputs return to reset values on the next clock and RESET_SEQ restarts. No partial rsp_valid is produced.
- Counters: a phase counter sized for CLK_DIV, a bit counter of max(IR_LEN,32) range, and a sequence step counter.

## Timing
- After reset deasserts: cmd_ready rises 6·2·CLK_DIV clocks later.
- Command latency, accept to rsp_valid: (IR_LEN+6 + (len>0 ? len+5 : 0))·2·CLK_DIV + 1 clocks.
- cmd_ready falls on the clock after accept and rises on the clock after rsp_valid.
- Back-to-back: a command presented during the rsp_valid cycle is not accepted; it is accepted one clock later in IDLE.
- TCK is glitch-free and registered. Duty cycle is exactly 50%. TCK frequency = f_clock / (2·CLK_DIV).

## Test plan
- Reset release, CLK_DIV=2: TMS=1 for 5 TCK rising edges, TMS=0 for the 6th → cmd_ready=1 at clock 24 after reset; TCK=0 throughout the idle period.
- TDO looped to TDI, IR_LEN=8: cmd_ir=0x32, len=8, data=0xA5 → 27 TCK edges, rsp_data=0x000000A5; a TAP state-machine model ends in Run-Test/Idle with IR=0x32.
- IR-only: len=0 → exactly 14 TCK edges, no DR states are visited, rsp_valid pulses once, rsp_data=0.
- Clamp: len=40, data=0xDEADBEEF, loopback → 37 DR-scan edges, rsp_data=0xDEADBEEF.
- TDO tied to 1, len=5 → rsp_data=0x0000001F (upper bits zero).
- reset pulse during DR shift bit 3 → TCK=0, TMS=1 next clock, no rsp_valid, full RESET_SEQ replays; a cmd_valid during busy is dropped.
